// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default widths, the stereo frame type and the channel encoding
// used by both the transmitter and the receiver.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOT_W = 32;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } i2s_frame_t;

    // Matches the lrck level: 0 selects the left slot, 1 the right slot.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-frame source port of the I2S transmitter.
// Handshake: a frame moves on any rising bck edge where s_valid && s_ready; the source keeps
// s_valid, s_left and s_right stable until that edge, and s_valid never waits for s_ready.
interface i2s_tx_if #(
    parameter int DATA_W = 24
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_frame_counter.sv
// Bit position within a stereo frame (0..2*SLOT_W-1). Exposes the slot and in-slot bit of the
// position being entered so that callers can register outputs aligned with it.
module i2s_frame_counter #(
    parameter  int SLOT_W = 32,
    localparam int KW     = $clog2(SLOT_W),
    localparam int PW     = $clog2(2 * SLOT_W)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          lrck_next,
    output logic [KW-1:0] slot_bit_next,
    output logic          frame_last
);
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;

    always_comb begin
        frame_last    = (pos_q == PW'(2 * SLOT_W - 1));
        pos_d         = frame_last ? '0 : pos_q + 1'b1;
        lrck_next     = (pos_d >= PW'(SLOT_W));
        slot_bit_next = lrck_next ? KW'(pos_d - PW'(SLOT_W)) : KW'(pos_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one pending frame buffer behind the frame currently on the wire,
// MSB-first serialisation onto din with a matching lrck, and an underrun pulse for silent frames.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = I2S_DATA_W,
    parameter int SLOT_W    = I2S_SLOT_W,
    parameter int MSB_DELAY = 1
) (
    input  logic     bck,
    input  logic     rst,
    i2s_tx_if.slave  s,
    output logic     lrck,
    output logic     din,
    output logic     underrun
);
    localparam int KW = $clog2(SLOT_W);

    logic              lrck_next;
    logic [KW-1:0]     slot_bit_next;
    logic              frame_last;

    logic [DATA_W-1:0] pend_l_q, pend_l_d;
    logic [DATA_W-1:0] pend_r_q, pend_r_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] cur_l_q, cur_l_d;
    logic [DATA_W-1:0] cur_r_q, cur_r_d;
    logic              lrck_q, lrck_d;
    logic              din_q, din_d;
    logic              underrun_q, underrun_d;

    logic              xfer;
    i2s_chan_e         chan;
    logic [DATA_W-1:0] data;
    int                k_int;

    i2s_frame_counter #(.SLOT_W(SLOT_W)) u_cnt (
        .clk          (bck),
        .rst          (rst),
        .lrck_next    (lrck_next),
        .slot_bit_next(slot_bit_next),
        .frame_last   (frame_last)
    );

    assign s.s_ready = !pend_valid_q && !rst;

    always_comb begin
        xfer         = s.s_valid && s.s_ready;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        pend_valid_d = pend_valid_q;
        cur_l_d      = cur_l_q;
        cur_r_d      = cur_r_q;
        underrun_d   = 1'b0;

        if (frame_last) begin
            if (pend_valid_q) begin
                cur_l_d      = pend_l_q;
                cur_r_d      = pend_r_q;
                pend_valid_d = 1'b0;
            end else if (xfer) begin
                // A frame arriving exactly on the boundary skips the pending register.
                cur_l_d = s.s_left;
                cur_r_d = s.s_right;
            end else begin
                cur_l_d    = '0;
                cur_r_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (xfer) begin
            pend_l_d     = s.s_left;
            pend_r_d     = s.s_right;
            pend_valid_d = 1'b1;
        end

        // Outputs are computed for the position being entered, so use the next cur values.
        lrck_d = lrck_next;
        chan   = lrck_next ? RIGHT : LEFT;
        data   = (chan == RIGHT) ? cur_r_d : cur_l_d;
        k_int  = int'(slot_bit_next);
        din_d  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (k_int == DATA_W - 1 + MSB_DELAY - i) din_d = data[i];
        end
    end

    always_ff @(posedge bck) begin
        if (rst) begin
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            pend_valid_q <= 1'b0;
            cur_l_q      <= '0;
            cur_r_q      <= '0;
            lrck_q       <= 1'b0;
            din_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            pend_valid_q <= pend_valid_d;
            cur_l_q      <= cur_l_d;
            cur_r_q      <= cur_r_d;
            lrck_q       <= lrck_d;
            din_q        <= din_d;
            underrun_q   <= underrun_d;
        end
    end

    assign lrck     = lrck_q;
    assign din      = din_q;
    assign underrun = underrun_q;

endmodule
